// File: rtl/bfp_pkg.sv
// Shared constants and types for the block-floating-point exponent stage.
package bfp_pkg;

  localparam int INPUT_WIDTH  = 23;
  localparam int OUTPUT_WIDTH = 11;
  localparam int SHIFT_WIDTH  = 5;
  localparam int SHIFT_TARGET = INPUT_WIDTH - OUTPUT_WIDTH;

  // One complex butterfly output as stored in the ping-pong buffer.
  typedef struct packed {
    logic signed [INPUT_WIDTH-1:0] re;
    logic signed [INPUT_WIDTH-1:0] im;
  } cplx_t;

  // Read side is either waiting for a completed bank or replaying one.
  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

endpackage

// File: rtl/sign_headroom.sv
// Combinational leading-sign counter: number of redundant sign bits of a
// two's-complement value (0 = no headroom, INPUT_WIDTH-1 = value is 0 or -1).
module sign_headroom #(
  parameter int INPUT_WIDTH = bfp_pkg::INPUT_WIDTH,
  parameter int SHIFT_WIDTH = bfp_pkg::SHIFT_WIDTH
) (
  input  logic [INPUT_WIDTH-1:0] value,
  output logic [SHIFT_WIDTH-1:0] headroom
);

  // differs[i] marks bits that no longer copy the sign bit.
  logic [INPUT_WIDTH-2:0] differs;

  for (genvar gi = 0; gi < INPUT_WIDTH - 1; gi++) begin : g_diff
    assign differs[gi] = value[gi] ^ value[INPUT_WIDTH-1];
  end

  // Priority encode the highest differing bit; later (higher) hits win.
  always_comb begin
    headroom = SHIFT_WIDTH'(INPUT_WIDTH - 1);
    for (int i = 0; i < INPUT_WIDTH - 1; i++) begin
      if (differs[i]) begin
        headroom = SHIFT_WIDTH'(INPUT_WIDTH - 2 - i);
      end
    end
  end

endmodule

// File: rtl/bfp_scale_detect.sv
// Block-floating-point exponent stage: buffers a frame in a ping-pong memory,
// tracks its minimum sign headroom, then replays it with a per-frame shift.
module bfp_scale_detect #(
  parameter int INPUT_WIDTH  = bfp_pkg::INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = bfp_pkg::OUTPUT_WIDTH,
  parameter int SHIFT_WIDTH  = bfp_pkg::SHIFT_WIDTH,
  parameter int SHIFT_TARGET = INPUT_WIDTH - OUTPUT_WIDTH,
  parameter int FRAME_LEN    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [INPUT_WIDTH-1:0] in_re,
  input  logic signed [INPUT_WIDTH-1:0] in_im,
  output logic                          out_valid,
  output logic signed [INPUT_WIDTH-1:0] out_re,
  output logic signed [INPUT_WIDTH-1:0] out_im,
  output logic [SHIFT_WIDTH-1:0]        out_shift,
  output logic                          out_sof,
  output logic                          out_eof
);
  import bfp_pkg::*;

  localparam int ADDR_W = $clog2(FRAME_LEN);
  localparam logic [ADDR_W-1:0]      LAST_ADDR    = ADDR_W'(FRAME_LEN - 1);
  localparam logic [SHIFT_WIDTH-1:0] HEADROOM_MAX = SHIFT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [SHIFT_WIDTH-1:0] SHIFT_MAX    = SHIFT_WIDTH'(SHIFT_TARGET);

  // Two banks of FRAME_LEN words, addressed as {bank, sample index}.
  logic [2*INPUT_WIDTH-1:0] mem [2*FRAME_LEN];

  logic [ADDR_W-1:0]            wcnt_reg;
  logic [ADDR_W-1:0]            rcnt_reg;
  logic                         wb_reg;
  logic                         rb_reg;
  logic [1:0]                   ready_reg;
  logic [1:0][SHIFT_WIDTH-1:0]  shift_reg;
  logic [SHIFT_WIDTH-1:0]       hmin_reg;
  logic [SHIFT_WIDTH-1:0]       h_re;
  logic [SHIFT_WIDTH-1:0]       h_im;
  logic [SHIFT_WIDTH-1:0]       h_frame;
  logic [SHIFT_WIDTH-1:0]       h_clamped;
  state_t                       state_reg;
  state_t                       state_next;
  logic                         frame_done;
  logic                         drain;
  logic                         eof;

  sign_headroom #(
    .INPUT_WIDTH(INPUT_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_headroom_re (
    .value   (in_re),
    .headroom(h_re)
  );

  sign_headroom #(
    .INPUT_WIDTH(INPUT_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_headroom_im (
    .value   (in_im),
    .headroom(h_im)
  );

  assign frame_done = in_valid && (wcnt_reg == LAST_ADDR);
  assign drain      = (state_reg == DRAIN);
  assign eof        = drain && (rcnt_reg == LAST_ADDR);

  // Running minimum including the current sample, and its clamp to the scaler range.
  always_comb begin
    h_frame = hmin_reg;
    if (h_re < h_frame) h_frame = h_re;
    if (h_im < h_frame) h_frame = h_im;
    h_clamped = (h_frame > SHIFT_MAX) ? SHIFT_MAX : h_frame;
  end

  // Sample storage; the write bank never equals the bank being drained.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[{wb_reg, wcnt_reg}] <= {in_re, in_im};
    end
  end

  // Write side: sample counter, headroom accumulator, per-bank shift and ready flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_reg  <= '0;
      wb_reg    <= 1'b0;
      hmin_reg  <= HEADROOM_MAX;
      shift_reg <= '0;
      ready_reg <= '0;
    end else begin
      if (in_valid) begin
        wcnt_reg <= wcnt_reg + 1'b1;
        if (frame_done) begin
          shift_reg[wb_reg] <= h_clamped;
          ready_reg[wb_reg] <= 1'b1;
          wb_reg            <= ~wb_reg;
          hmin_reg          <= HEADROOM_MAX;
        end else begin
          hmin_reg <= h_frame;
        end
      end
      // A completing frame and a finishing drain always touch different banks.
      if (eof) begin
        ready_reg[rb_reg] <= 1'b0;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Read FSM next state: start on any ready bank, chain straight into the other bank.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|ready_reg) state_next = DRAIN;
      DRAIN:   if (eof && !ready_reg[~rb_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Replay path: registered memory read plus framing flags; data and shift hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_reg  <= '0;
      rb_reg    <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_shift <= '0;
    end else if (drain) begin
      out_valid        <= 1'b1;
      {out_re, out_im} <= mem[{rb_reg, rcnt_reg}];
      out_shift        <= shift_reg[rb_reg];
      out_sof          <= (rcnt_reg == '0);
      out_eof          <= eof;
      rcnt_reg         <= rcnt_reg + 1'b1;
      if (eof) begin
        rb_reg <= ~rb_reg;
      end
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bfp_scale_detect.sv
// Self-checking bench for bfp_scale_detect: table vectors, hand-written
// corner sequences and randomized frames against a range-based headroom model.
module tb_bfp_scale_detect;
  import bfp_pkg::*;

  localparam int FL = 16;
  localparam int W  = INPUT_WIDTH;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic signed [W-1:0]    in_re = '0;
  logic signed [W-1:0]    in_im = '0;
  logic                   out_valid;
  logic signed [W-1:0]    out_re;
  logic signed [W-1:0]    out_im;
  logic [SHIFT_WIDTH-1:0] out_shift;
  logic                   out_sof;
  logic                   out_eof;

  bfp_scale_detect #(.FRAME_LEN(FL)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_shift(out_shift),
    .out_sof  (out_sof),
    .out_eof  (out_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    cplx_t [FL-1:0]         s;
    logic [SHIFT_WIDTH-1:0] shift;
    int                     done_cyc;
  } frame_t;

  // One special sample at position pos, the rest a small ramp (headroom 18).
  typedef struct {
    int pos;
    int re;
    int im;
    int shift;
  } vec_t;

  vec_t   tbl[12];
  frame_t exp_q[$];
  frame_t cur;
  int     cyc = 0;
  int     chk = 0;
  int     pass = 0;
  int     idx = 0;
  int     run_len = 0;
  int     last_run = 0;
  int     frames_seen = 0;
  bit     in_frame = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input string detail);
    chk++;
    if (ok) pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Headroom from its definition: smallest n with -2^n <= x < 2^n gives W-1-n.
  function automatic int ref_h(input longint x);
    for (int n = 0; n < W; n++) begin
      if (x >= -(longint'(1) <<< n) && x < (longint'(1) <<< n)) return W - 1 - n;
    end
    return 0;
  endfunction

  function automatic frame_t build_frame(input vec_t v);
    frame_t f;
    for (int i = 0; i < FL; i++) begin
      f.s[i].re = W'(i);
      f.s[i].im = W'(-i);
    end
    f.s[v.pos].re = W'(v.re);
    f.s[v.pos].im = W'(v.im);
    f.shift       = SHIFT_WIDTH'(v.shift);
    f.done_cyc    = 0;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    int     k;
    int     h;
    k = int'($urandom_range(0, W - 1));
    h = SHIFT_TARGET;
    for (int i = 0; i < FL; i++) begin
      f.s[i].re = W'(longint'($urandom_range(0, (1 << (k + 1)) - 1)) - (longint'(1) << k));
      f.s[i].im = W'(longint'($urandom_range(0, (1 << (k + 1)) - 1)) - (longint'(1) << k));
      if (ref_h(f.s[i].re) < h) h = ref_h(f.s[i].re);
      if (ref_h(f.s[i].im) < h) h = ref_h(f.s[i].im);
    end
    f.shift    = SHIFT_WIDTH'(h);
    f.done_cyc = 0;
    return f;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_re    = W'($urandom);
      in_im    = W'($urandom);
    end
  endtask

  // Drive one frame with optional random bubbles; queue it as expected output.
  task automatic send_frame(input frame_t f, input int bubble_pct);
    for (int i = 0; i < FL; i++) begin
      while (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct) idle(1);
      @(negedge clk);
      in_valid = 1'b1;
      in_re    = f.s[i].re;
      in_im    = f.s[i].im;
      if (i == FL - 1) begin
        f.done_cyc = cyc + 1;
        exp_q.push_back(f);
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 300) begin
      idle(1);
      n++;
    end
    check(n < 300, "drain_timeout", $sformatf("waited %0d cycles, required < 300", n));
    idle(4);
  endtask

  task automatic check_outputs_zero(input string name);
    check(out_valid == 0 && out_sof == 0 && out_eof == 0 && out_re == 0 && out_im == 0 && out_shift == 0,
          name, $sformatf("valid=%0b sof=%0b eof=%0b re=%0d im=%0d shift=%0d, required all 0",
                          out_valid, out_sof, out_eof, out_re, out_im, out_shift));
  endtask

  // Call right after a falling edge; asserts rst clear of the monitor's sampling.
  task automatic apply_reset(input int cycles);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    in_frame = 1'b0;
    run_len  = 0;
    #1;
    check_outputs_zero("reset_async");
    repeat (cycles) begin
      @(negedge clk);
      check_outputs_zero("reset_hold");
    end
    rst = 1'b0;
  endtask

  // Output monitor: compares every replayed sample, latency, framing and contiguity.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          run_len++;
          if (!in_frame) begin
            if (exp_q.size() == 0) begin
              check(1'b0, "unexpected_valid", $sformatf("out_valid=1 at cycle %0d, required 0", cyc));
            end else begin
              cur      = exp_q.pop_front();
              in_frame = 1'b1;
              idx      = 0;
              check(cyc == cur.done_cyc + 2, "latency",
                    $sformatf("first output at cycle %0d, required %0d", cyc, cur.done_cyc + 2));
            end
          end
          if (in_frame) begin
            check(out_re == cur.s[idx].re && out_im == cur.s[idx].im && out_shift == cur.shift &&
                  out_sof == (idx == 0) && out_eof == (idx == FL - 1), "sample",
                  $sformatf("idx %0d got re=%0d im=%0d shift=%0d sof=%0b eof=%0b, required re=%0d im=%0d shift=%0d sof=%0b eof=%0b",
                            idx, out_re, out_im, out_shift, out_sof, out_eof,
                            cur.s[idx].re, cur.s[idx].im, cur.shift, idx == 0, idx == FL - 1));
            idx++;
            if (idx == FL) begin
              in_frame = 1'b0;
              frames_seen++;
              $display("frame %0d replayed: shift=%0d", frames_seen, cur.shift);
            end
          end
        end else begin
          if (run_len != 0) last_run = run_len;
          run_len = 0;
          if (in_frame) begin
            check(1'b0, "gap", $sformatf("out_valid=0 at frame index %0d, required 1", idx));
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t fa;
    frame_t fb;
    frame_t fz;
    int     n;

    tbl = '{
      '{0,  -4194304, 0,        0},
      '{3,  1023,     -1024,    12},
      '{15, 1024,     0,        11},
      '{7,  262144,   0,        3},
      '{9,  0,        4096,     9},
      '{1,  0,        -2097152, 1},
      '{12, 2097151,  5,        1},
      '{5,  4194303,  0,        0},
      '{0,  -1,       -1,       12},
      '{14, -4097,    0,        9},
      '{2,  2048,     -2049,    10},
      '{6,  511,      0,        12}
    };

    // Power-up reset.
    @(negedge clk);
    apply_reset(3);
    idle(2);

    // Reset in the middle of an input frame: partial data must never appear.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_re    = W'($urandom);
      in_im    = W'($urandom);
    end
    @(negedge clk);
    apply_reset(3);
    idle(30);

    // All-zero frame: full headroom clamps to the target shift.
    for (int i = 0; i < FL; i++) fz.s[i] = '0;
    fz.shift = SHIFT_WIDTH'(12);
    send_frame(fz, 0);
    wait_drain();

    // Table vectors, one frame each, with the held outputs checked afterwards.
    for (int r = 0; r < 12; r++) begin
      fa = build_frame(tbl[r]);
      $display("vector %0d: sample %0d re=%0d im=%0d expect shift=%0d",
               r, tbl[r].pos, tbl[r].re, tbl[r].im, tbl[r].shift);
      send_frame(fa, 0);
      wait_drain();
      check(out_re == fa.s[FL-1].re && out_im == fa.s[FL-1].im && out_shift == fa.shift &&
            out_valid == 0 && out_sof == 0 && out_eof == 0, "hold",
            $sformatf("idle re=%0d im=%0d shift=%0d valid=%0b, required re=%0d im=%0d shift=%0d valid=0",
                      out_re, out_im, out_shift, out_valid, fa.s[FL-1].re, fa.s[FL-1].im, fa.shift));
    end

    // Back-to-back full-rate frames: one unbroken 32-sample output burst.
    send_frame(build_frame(tbl[3]), 0);
    send_frame(build_frame(tbl[4]), 0);
    wait_drain();
    check(last_run == 2 * FL, "b2b_run", $sformatf("burst %0d cycles, required %0d", last_run, 2 * FL));

    // Second frame completes on the first frame's eof cycle.
    send_frame(build_frame(tbl[9]), 0);
    idle(1);
    send_frame(build_frame(tbl[10]), 0);
    wait_drain();
    check(last_run == FL, "eof_collide_run", $sformatf("burst %0d cycles, required %0d", last_run, FL));

    // Same random frame gap-free then with 50% bubbles.
    fa = rand_frame();
    send_frame(fa, 0);
    wait_drain();
    send_frame(fa, 50);
    wait_drain();

    // Continuous random stream with mixed bubble rates.
    for (int k = 0; k < 10; k++) begin
      fb = rand_frame();
      send_frame(fb, (k % 3 == 0) ? 0 : ((k % 3 == 1) ? 30 : 50));
    end
    wait_drain();

    // Reset while sample 5 of a frame is on the output.
    send_frame(build_frame(tbl[7]), 0);
    n = 0;
    do begin
      idle(1);
      n++;
    end while (!(out_valid && out_sof) && n < 50);
    check(n < 50, "sof_wait", $sformatf("waited %0d cycles for sof, required < 50", n));
    idle(5);
    check(out_valid == 1 && out_sof == 0, "mid_drain_state",
          $sformatf("valid=%0b sof=%0b before reset, required valid=1 sof=0", out_valid, out_sof));
    apply_reset(2);
    idle(20);
    send_frame(build_frame(tbl[1]), 0);
    wait_drain();

    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
